// File: rtl/irq_controller_pkg.sv
// Shared types and constants for the interrupt controller: FSM encoding,
// source identifiers and the fixed-priority source pick.
package irq_controller_pkg;

    localparam int unsigned PC_W_DEFAULT = 10;

    localparam logic SRC_TIMER = 1'b0;
    localparam logic SRC_EXT   = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPATCH = 2'd1,
        S_ISR      = 2'd2
    } state_e;

    // Timer source always beats the external line when both are eligible.
    function automatic logic pick_src(input logic [1:0] grant);
        if (grant[0]) begin
            return SRC_TIMER;
        end else begin
            return SRC_EXT;
        end
    endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Bus between the CPU control path and the interrupt controller.
// master = CPU/system side, slave = the controller.
interface irq_controller_if
    import irq_controller_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEFAULT
);
    logic [1:0]      irq_in;
    logic [1:0]      irq_mask;
    logic            ei;
    logic            di;
    logic            reti;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] vec0;
    logic [PC_W-1:0] vec1;
    logic            take_irq;
    logic            push_en;
    logic [PC_W-1:0] push_addr;
    logic [PC_W-1:0] irq_vector;
    logic            in_isr;
    logic            active_src;
    logic            reti_err;

    modport master (
        output irq_in, irq_mask, ei, di, reti, pc_next, vec0, vec1,
        input  take_irq, push_en, push_addr, irq_vector, in_isr, active_src, reti_err
    );

    modport slave (
        input  irq_in, irq_mask, ei, di, reti, pc_next, vec0, vec1,
        output take_irq, push_en, push_addr, irq_vector, in_isr, active_src, reti_err
    );

endinterface

// File: rtl/irq_controller_pending_cell.sv
// One request source: input sampling flop, optional rising-edge detect and
// a pending latch in which a new request beats a simultaneous clear.
module irq_pending_cell
    import irq_controller_pkg::*;
#(
    parameter bit EDGE_TRIG = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic clr,
    output logic pend
);

    logic req_q;
    logic pend_q;
    logic pend_d;
    logic set_s;

    // Request detection: rising edge or plain level depending on EDGE_TRIG.
    always_comb begin
        if (EDGE_TRIG) begin
            set_s = req & ~req_q;
        end else begin
            set_s = req;
        end
    end

    // Pending next state; set has priority so a coincident request survives dispatch.
    always_comb begin
        if (set_s) begin
            pend_d = 1'b1;
        end else if (clr) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
    end

    // Sample flop and pending flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            req_q  <= req;
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller top: global enable, two pending cells, fixed-priority
// arbiter, IDLE/DISPATCH/ISR sequencer and the vector/return-address registers.
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int unsigned PC_W      = PC_W_DEFAULT,
    parameter bit          EDGE_TRIG = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    irq_controller_if.slave  bus
);

    state_e          state_q, state_d;
    logic            ie_q, ie_d;
    logic            src_q, src_d;
    logic [PC_W-1:0] vec_q, vec_d;
    logic [PC_W-1:0] ret_q, ret_d;
    logic            err_q, err_d;

    logic [1:0] pend_s;
    logic [1:0] clr_s;
    logic [1:0] grant_s;
    logic       go_s;
    logic       src_s;
    logic       take_s;
    logic       in_isr_s;

    for (genvar g = 0; g < 2; g++) begin : g_cell
        irq_pending_cell #(.EDGE_TRIG(EDGE_TRIG)) u_cell (
            .clk   (clk),
            .reset (reset),
            .req   (bus.irq_in[g]),
            .clr   (clr_s[g]),
            .pend  (pend_s[g])
        );
    end

    assign grant_s = pend_s & bus.irq_mask;
    assign src_s   = pick_src(grant_s);
    assign go_s    = ie_q & (|grant_s) & (state_q == S_IDLE);

    // Pending clear for the source being dispatched.
    always_comb begin
        clr_s = 2'b00;
        if (go_s) begin
            clr_s[src_s] = 1'b1;
        end else begin
            clr_s = 2'b00;
        end
    end

    // Global enable; di wins over a simultaneous ei.
    always_comb begin
        if (bus.di) begin
            ie_d = 1'b0;
        end else if (bus.ei) begin
            ie_d = 1'b1;
        end else begin
            ie_d = ie_q;
        end
    end

    // Dispatch context captured only when a dispatch is committed.
    always_comb begin
        if (go_s) begin
            src_d = src_s;
            vec_d = (src_s == SRC_EXT) ? bus.vec1 : bus.vec0;
            ret_d = bus.pc_next;
        end else begin
            src_d = src_q;
            vec_d = vec_q;
            ret_d = ret_q;
        end
    end

    // Sticky error for a reti that arrives outside an ISR.
    always_comb begin
        if (bus.reti && (state_q != S_ISR)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (go_s) begin
                    state_d = S_DISPATCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DISPATCH: state_d = S_ISR;
            S_ISR: begin
                if (bus.reti) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ISR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the state register.
    always_comb begin
        take_s   = 1'b0;
        in_isr_s = 1'b0;
        case (state_q)
            S_DISPATCH: take_s   = 1'b1;
            S_ISR:      in_isr_s = 1'b1;
            default: begin
                take_s   = 1'b0;
                in_isr_s = 1'b0;
            end
        endcase
    end

    // State and context registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ie_q    <= 1'b0;
            src_q   <= 1'b0;
            vec_q   <= {PC_W{1'b0}};
            ret_q   <= {PC_W{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ie_q    <= ie_d;
            src_q   <= src_d;
            vec_q   <= vec_d;
            ret_q   <= ret_d;
            err_q   <= err_d;
        end
    end

    assign bus.take_irq   = take_s;
    assign bus.push_en    = take_s;
    assign bus.push_addr  = ret_q;
    assign bus.irq_vector = vec_q;
    assign bus.in_isr     = in_isr_s;
    assign bus.active_src = src_q;
    assign bus.reti_err   = err_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: a request-level model checked every cycle
// plus hand-computed expectations at key points of each scenario.
module tb_irq_controller;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    irq_controller_if #(.PC_W(10)) bus ();

    irq_controller #(.PC_W(10), .EDGE_TRIG(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: pending requests as a set, controller mode as idle/taking/serving.
    bit [1:0]   m_prev, m_pend, m_req, m_ready;
    bit         m_ie, m_err, m_src, m_fire;
    int         m_mode;
    logic [9:0] m_vec, m_ret;

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_prev = 2'b00; m_pend = 2'b00; m_ie = 1'b0; m_err = 1'b0;
                m_src = 1'b0; m_mode = 0; m_vec = 10'h000; m_ret = 10'h000;
            end else begin
                for (int i = 0; i < 2; i++) m_req[i] = bus.irq_in[i] && !m_prev[i];
                m_ready = m_pend & bus.irq_mask;
                m_fire  = m_ie && (m_mode == 0) && (m_ready != 2'b00);
                if (bus.reti && m_mode != 2) m_err = 1'b1;
                if (m_mode == 1) m_mode = 2;
                else if (m_mode == 2 && bus.reti) m_mode = 0;
                else if (m_fire) m_mode = 1;
                if (m_fire) begin
                    m_src = m_ready[0] ? 1'b0 : 1'b1;
                    m_pend[m_src] = 1'b0;
                    m_vec = m_src ? bus.vec1 : bus.vec0;
                    m_ret = bus.pc_next;
                end
                m_pend = m_pend | m_req;
                if (bus.di) m_ie = 1'b0;
                else if (bus.ei) m_ie = 1'b1;
                m_prev = bus.irq_in;
            end
        end
    end

    function automatic logic [24:0] pack_out();
        return {bus.take_irq, bus.push_en, bus.push_addr, bus.irq_vector,
                bus.in_isr, bus.active_src, bus.reti_err};
    endfunction

    // Per-cycle comparison against the model.
    initial begin
        logic [24:0] exp_v, act_v;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                exp_v = {(m_mode == 1), (m_mode == 1), m_ret, m_vec,
                         (m_mode == 2), m_src, m_err};
                act_v = pack_out();
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL model_cycle t=%0t: got take=%b push=%b pa=%h vec=%h isr=%b src=%b err=%b, expected %h", $time,
                             act_v[24], act_v[23], act_v[22:13], act_v[12:3], act_v[2], act_v[1], act_v[0], exp_v);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_take(input int budget, input string name);
        bit found = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (bus.take_irq === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, found}, 32'd1);
    endtask

    task automatic count_takes(input int cycles, input string name);
        int seen = 0;
        for (int n = 0; n < cycles; n++) begin
            tick();
            if (bus.take_irq !== 1'b0) seen++;
        end
        chk(name, seen, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.irq_in = 2'b00; bus.irq_mask = 2'b00; bus.ei = 1'b0; bus.di = 1'b0;
        bus.reti = 1'b0; bus.pc_next = 10'h000; bus.vec0 = 10'h000; bus.vec1 = 10'h000;
        #1 reset = 1'b0;
        #2 chk("reset_state", {7'd0, pack_out()}, 32'd0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // Single timer request: two-cycle latency, vector and return address.
        bus.ei = 1'b1; bus.irq_mask = 2'b11; bus.vec0 = 10'h080; bus.vec1 = 10'h0C0; bus.pc_next = 10'h013;
        tick();
        bus.ei = 1'b0; bus.irq_in = 2'b01;
        tick(); chk("t2_no_take_k", {31'd0, bus.take_irq}, 32'd0);
        tick(); chk("t2_take", {30'd0, bus.take_irq, bus.push_en}, 32'd3);
        chk("t2_vector", {22'd0, bus.irq_vector}, 32'h080);
        chk("t2_push_addr", {22'd0, bus.push_addr}, 32'h013);
        tick(); chk("t2_in_isr", {30'd0, bus.take_irq, bus.in_isr}, 32'd1);
        bus.irq_in = 2'b00; bus.reti = 1'b1;
        tick(); bus.reti = 1'b0;
        chk("t2_reti_idle", {31'd0, bus.in_isr}, 32'd0);
        tick();

        // Both sources together: timer first, external one cycle after reti.
        bus.irq_in = 2'b11;
        tick(); tick();
        chk("t3_first_vec", {21'd0, bus.take_irq, bus.irq_vector}, 32'h480);
        chk("t3_first_src", {31'd0, bus.active_src}, 32'd0);
        tick(); chk("t3_isr", {31'd0, bus.in_isr}, 32'd1);
        bus.reti = 1'b1; bus.irq_in = 2'b00;
        tick(); bus.reti = 1'b0;
        chk("t3_idle_gap", {30'd0, bus.in_isr, bus.take_irq}, 32'd0);
        tick();
        chk("t3_second_vec", {21'd0, bus.take_irq, bus.irq_vector}, 32'h4C0);
        chk("t3_second_src", {31'd0, bus.active_src}, 32'd1);
        tick(); chk("t3_isr2", {30'd0, bus.in_isr, bus.active_src}, 32'd3);
        bus.reti = 1'b1;
        tick(); bus.reti = 1'b0;
        tick();

        // Disabled interrupts hold the request until ei.
        bus.di = 1'b1;
        tick(); bus.di = 1'b0; bus.irq_in = 2'b10;
        count_takes(20, "t4_no_take_ie0");
        bus.irq_in = 2'b00; bus.ei = 1'b1;
        tick(); bus.ei = 1'b0;
        wait_take(1, "t4_ei_dispatch");
        chk("t4_vector", {22'd0, bus.irq_vector}, 32'h0C0);
        tick(); bus.reti = 1'b1;
        tick(); bus.reti = 1'b0;
        tick();

        // Request during ISR waits for reti; coincident edge survives the clear.
        bus.irq_in = 2'b01;
        wait_take(2, "t5_first_take");
        tick(); bus.irq_in = 2'b00;
        tick(); bus.irq_in = 2'b01;
        count_takes(5, "t5_no_take_in_isr");
        bus.irq_in = 2'b00; bus.reti = 1'b1;
        tick(); bus.reti = 1'b0; bus.irq_in = 2'b01;
        tick(); chk("t5_take_after_reti", {21'd0, bus.take_irq, bus.irq_vector}, 32'h480);
        tick(); bus.reti = 1'b1; bus.irq_in = 2'b00;
        tick(); bus.reti = 1'b0;
        wait_take(2, "t5_pend_kept");
        tick(); bus.reti = 1'b1;
        tick(); bus.reti = 1'b0;
        count_takes(4, "t5_drained");

        // Stray reti and simultaneous ei/di.
        chk("t6_err_clear", {31'd0, bus.reti_err}, 32'd0);
        bus.reti = 1'b1;
        tick(); bus.reti = 1'b0;
        chk("t6_err_set", {29'd0, bus.reti_err, bus.in_isr, bus.take_irq}, 32'd4);
        tick(); chk("t6_err_sticky", {31'd0, bus.reti_err}, 32'd1);
        bus.ei = 1'b1; bus.di = 1'b1;
        tick(); bus.ei = 1'b0; bus.di = 1'b0; bus.irq_in = 2'b10;
        count_takes(5, "t6_ei_di_disabled");
        bus.irq_in = 2'b00;

        // Asynchronous reset in the middle of an ISR.
        bus.ei = 1'b1;
        tick(); bus.ei = 1'b0;
        wait_take(2, "t1_dispatch");
        tick(); chk("t1_in_isr", {31'd0, bus.in_isr}, 32'd1);
        #3 reset = 1'b0;
        #1 chk("t1_async_reset", {7'd0, pack_out()}, 32'd0);
        tick(); reset = 1'b1;
        tick(); tick();
        chk("t1_after_reset", {30'd0, bus.in_isr, bus.reti_err}, 32'd0);
        count_takes(3, "t1_pending_lost");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
